// File: rtl/fetch_out_pkg_hdl.sv
// Shared definitions for the LC3 fetch stage and its fetch_out bus.
package fetch_out_pkg_hdl;

  localparam int unsigned LC3_ADDR_W = 16;
  localparam logic [LC3_ADDR_W-1:0] LC3_RESET_PC = 16'h3000;

  // Width of the REQ-state timeout counter (TIMEOUT limited to 1..255).
  localparam int unsigned LC3_TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Sequential successor of an address, wrapping at the top of memory.
  function automatic logic [LC3_ADDR_W-1:0] lc3_pc_inc(input logic [LC3_ADDR_W-1:0] a);
    return a + {{(LC3_ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/lc3_fetch_pc_reg.sv
// Program counter, pending-redirect register and PC update priority mux.
// A redirect seen while no update is permitted is parked and applied on the
// next update cycle; a newer redirect replaces a parked one.
module lc3_fetch_pc_reg
  import fetch_out_pkg_hdl::*;
#(
  parameter logic [LC3_ADDR_W-1:0] RESET_PC = LC3_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_updatePC,
  input  logic                  br_taken,
  input  logic [LC3_ADDR_W-1:0] taddr,
  output logic [LC3_ADDR_W-1:0] pc,
  output logic [LC3_ADDR_W-1:0] npc
);

  logic                  pend_vld;
  logic [LC3_ADDR_W-1:0] pend_addr;
  logic [LC3_ADDR_W-1:0] pc_nxt;
  logic                  pend_vld_nxt;
  logic [LC3_ADDR_W-1:0] pend_addr_nxt;

  assign npc = lc3_pc_inc(pc);

  // Update priority: live redirect, then parked redirect, then sequential.
  always_comb begin
    pc_nxt        = pc;
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    if (enable_updatePC) begin
      pend_vld_nxt = 1'b0;
      if (br_taken) begin
        pc_nxt = taddr;
      end else if (pend_vld) begin
        pc_nxt = pend_addr;
      end else begin
        pc_nxt = npc;
      end
    end else if (br_taken) begin
      pend_vld_nxt  = 1'b1;
      pend_addr_nxt = taddr;
    end
  end

  // PC and pending-redirect registers; reset drops any parked redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else begin
      pc        <= pc_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: owns the PC and drives the fetch_out bus (npc, pc,
// instrmem_rd) with a request/ready handshake to instruction memory.
// Optional macro FETCH_TRISTATE_EN: release instrmem_rd (1'bz) whenever
// enable_fetch is low, for use on a shared tri-state bus.
module lc3_fetch_unit
  import fetch_out_pkg_hdl::*;
#(
  parameter logic [LC3_ADDR_W-1:0] RESET_PC = LC3_RESET_PC,
  parameter int unsigned           TIMEOUT  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_fetch,
  input  logic                  enable_updatePC,
  input  logic                  br_taken,
  input  logic [LC3_ADDR_W-1:0] taddr,
  input  logic                  instrmem_rdy,
  output logic [LC3_ADDR_W-1:0] npc,
  output logic [LC3_ADDR_W-1:0] pc,
  output logic                  instrmem_rd,
  output logic                  fetch_done,
  output logic                  fetch_timeout,
  output logic [15:0]           fetch_count
);

  localparam logic [LC3_TMO_W-1:0] TMO_LIMIT = LC3_TMO_W'(TIMEOUT);

  fetch_state_t         state, state_nxt;
  logic [LC3_TMO_W-1:0] tmo_cnt, tmo_cnt_nxt, tmo_cnt_inc;
  logic                 tmo_hit;
  logic                 rd_int;
  logic                 cnt_inc;

  lc3_fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock           (clock),
    .reset           (reset),
    .enable_updatePC (enable_updatePC),
    .br_taken        (br_taken),
    .taddr           (taddr),
    .pc              (pc),
    .npc             (npc)
  );

  assign tmo_cnt_inc = tmo_cnt + {{(LC3_TMO_W-1){1'b0}}, 1'b1};

  // Fetch handshake: next state, request/done decode, timeout detection.
  always_comb begin
    state_nxt  = state;
    tmo_hit    = 1'b0;
    rd_int     = 1'b0;
    fetch_done = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_fetch) state_nxt = REQ;
      end
      REQ: begin
        rd_int = 1'b1;
        if (instrmem_rdy) begin
          state_nxt = DONE;
        end else if (!enable_fetch) begin
          state_nxt = IDLE;
        end else if (tmo_cnt_inc == TMO_LIMIT) begin
          state_nxt = IDLE;
          tmo_hit   = 1'b1;
        end
      end
      DONE: begin
        fetch_done = 1'b1;
        cnt_inc    = 1'b1;
        state_nxt  = enable_fetch ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout counter restarts on every entry to REQ and ages while in REQ.
  always_comb begin
    tmo_cnt_nxt = tmo_cnt;
    if (state_nxt == REQ && state != REQ) begin
      tmo_cnt_nxt = '0;
    end else if (state == REQ) begin
      tmo_cnt_nxt = tmo_cnt_inc;
    end
  end

  // FSM state, timeout counter, sticky timeout flag and completion counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      fetch_timeout <= 1'b0;
      fetch_count   <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      if (tmo_hit) fetch_timeout <= 1'b1;
      if (cnt_inc) fetch_count <= fetch_count + 16'd1;
    end
  end

`ifdef FETCH_TRISTATE_EN
  assign instrmem_rd = enable_fetch ? rd_int : 1'bz;
`else
  assign instrmem_rd = rd_int;
`endif

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a reference model.
module tb_lc3_fetch_unit;

  localparam int TMO = 15;

  logic        clock = 1'b0;
  logic        reset, enable_fetch, enable_updatePC, br_taken, instrmem_rdy;
  logic [15:0] taddr;
  logic [15:0] npc, pc, fetch_count;
  logic        instrmem_rd, fetch_done, fetch_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  lc3_fetch_unit #(
    .RESET_PC (16'h3000),
    .TIMEOUT  (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable_fetch    (enable_fetch),
    .enable_updatePC (enable_updatePC),
    .br_taken        (br_taken),
    .taddr           (taddr),
    .instrmem_rdy    (instrmem_rdy),
    .npc             (npc),
    .pc              (pc),
    .instrmem_rd     (instrmem_rd),
    .fetch_done      (fetch_done),
    .fetch_timeout   (fetch_timeout),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, ef, eu, br, input logic [15:0] ta, input logic rdy);
    reset = r; enable_fetch = ef; enable_updatePC = eu;
    br_taken = br; taddr = ta; instrmem_rdy = rdy;
  endtask

  // Expected request line given the FSM-level expectation and current enable.
  function automatic logic rd_expect(input logic fsm_rd);
`ifdef FETCH_TRISTATE_EN
    if (!enable_fetch) return 1'bz;
`endif
    return fsm_rd;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r, ef, eu, br;
    logic [15:0] ta;
    logic rdy;
    logic [15:0] pc;
    logic rd, done, to;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, ef, eu, br, input logic [15:0] ta, input logic rdy,
                     input logic [15:0] p, input logic rd, dn, to, input logic [15:0] cnt);
    vec_t v;
    v.r = r; v.ef = ef; v.eu = eu; v.br = br; v.ta = ta; v.rdy = rdy;
    v.pc = p; v.rd = rd; v.done = dn; v.to = to; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  int          m_pc;
  logic [15:0] m_pend[$];
  int          m_req_age;   // -1: no request outstanding, else cycles spent requesting
  bit          m_done;
  bit          m_to;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 'h3000; m_pend.delete(); m_req_age = -1; m_done = 0; m_to = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (enable_updatePC) begin
      if (br_taken) m_pc = int'(taddr);
      else if (m_pend.size() > 0) m_pc = int'(m_pend[$]);
      else m_pc = (m_pc + 1) % 65536;
      m_pend.delete();
    end else if (br_taken) begin
      m_pend.push_back(taddr);
    end
    if (m_done) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_done = 0;
      m_req_age = enable_fetch ? 0 : -1;
    end else if (m_req_age >= 0) begin
      if (instrmem_rdy) begin
        m_done = 1; m_req_age = -1;
      end else if (!enable_fetch) begin
        m_req_age = -1;
      end else if (m_req_age + 1 >= TMO) begin
        m_to = 1; m_req_age = -1;
      end else begin
        m_req_age++;
      end
    end else if (enable_fetch) begin
      m_req_age = 0;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Reset, sequential updates, 2-cycle request, parked and live redirects,
    // back-to-back fetch and abort.
    add(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h3000,1'b0,1'b0,1'b0,16'd0);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h3001,1'b0,1'b0,1'b0,16'd0);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h3002,1'b0,1'b0,1'b0,16'd0);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h3003,1'b0,1'b0,1'b0,16'd0);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h3003,1'b1,1'b0,1'b0,16'd0);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h3003,1'b1,1'b0,1'b0,16'd0);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b1, 16'h3003,1'b0,1'b1,1'b0,16'd0);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h3003,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b0,1'b1,16'h4000,1'b0, 16'h3003,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h3003,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h4000,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h4001,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b1,1'b1,16'h1234,1'b0, 16'h1234,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b0,1'b1,16'h5555,1'b0, 16'h1234,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b0,1'b1,16'h6666,1'b0, 16'h1234,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h6666,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 16'h6667,1'b0,1'b0,1'b0,16'd1);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h6667,1'b1,1'b0,1'b0,16'd1);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b1, 16'h6667,1'b0,1'b1,1'b0,16'd1);
    add(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 16'h6667,1'b1,1'b0,1'b0,16'd2);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h6667,1'b0,1'b0,1'b0,16'd2);
    add(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0, 16'h6667,1'b0,1'b0,1'b0,16'd2);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ef, tbl[i].eu, tbl[i].br, tbl[i].ta, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d npc", i), npc, tbl[i].pc + 16'd1);
      chk($sformatf("tbl%0d rd", i), {15'd0, instrmem_rd}, {15'd0, rd_expect(tbl[i].rd)});
      chk($sformatf("tbl%0d done", i), {15'd0, fetch_done}, {15'd0, tbl[i].done});
      chk($sformatf("tbl%0d to", i), {15'd0, fetch_timeout}, {15'd0, tbl[i].to});
      chk($sformatf("tbl%0d cnt", i), fetch_count, tbl[i].cnt);
    end

    // Timeout: request held TMO cycles without ready, then sticky flag.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      step();
      chk($sformatf("tmo req%0d rd", k), {15'd0, instrmem_rd}, 16'd1);
      chk($sformatf("tmo req%0d to", k), {15'd0, fetch_timeout}, 16'd0);
    end
    step();
    chk("tmo expire rd", {15'd0, instrmem_rd}, 16'd0);
    chk("tmo expire to", {15'd0, fetch_timeout}, 16'd1);
    step();
    chk("tmo rereq rd", {15'd0, instrmem_rd}, 16'd1);
    instrmem_rdy = 1'b1;
    step();
    chk("tmo fetch done", {15'd0, fetch_done}, 16'd1);
    chk("tmo sticky1", {15'd0, fetch_timeout}, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    chk("tmo cnt", fetch_count, 16'd1);
    chk("tmo sticky2", {15'd0, fetch_timeout}, 16'd1);

    // PC wrap at the top of the address space.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    step();
    chk("wrap pc ffff", pc, 16'hFFFF);
    chk("wrap npc 0000", npc, 16'h0000);
    br_taken = 1'b0;
    step();
    chk("wrap pc 0000", pc, 16'h0000);
    chk("wrap npc 0001", npc, 16'h0001);

    // Reset mid-REQ with a parked redirect.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    chk("midrst req rd", {15'd0, instrmem_rd}, 16'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h7777, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    chk("midrst rd", {15'd0, instrmem_rd}, 16'd0);
    chk("midrst pc", pc, 16'h3000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step();
    chk("midrst pend dropped", pc, 16'h3001);
    enable_updatePC = 1'b0;
    step();
`ifdef FETCH_TRISTATE_EN
    chk("idle rd released", {15'd0, instrmem_rd}, {15'd0, 1'bz});
`else
    chk("idle rd low", {15'd0, instrmem_rd}, 16'd0);
`endif

    // Randomized traffic against the reference model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    model_edge();
    step();
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(99) < 2);
      enable_fetch    = ($urandom_range(99) < 85);
      enable_updatePC = ($urandom_range(99) < 40);
      br_taken        = ($urandom_range(99) < 25);
      taddr           = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom);
      instrmem_rdy    = ($urandom_range(99) < ((n < 1500) ? 30 : 3));
      model_edge();
      step();
      chk("rnd pc", pc, 16'(m_pc));
      chk("rnd npc", npc, 16'((m_pc + 1) % 65536));
      chk("rnd rd", {15'd0, instrmem_rd}, {15'd0, rd_expect(m_req_age >= 0)});
      chk("rnd done", {15'd0, fetch_done}, {15'd0, m_done});
      chk("rnd to", {15'd0, fetch_timeout}, {15'd0, m_to});
      chk("rnd cnt", fetch_count, 16'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
